// File: rtl/ram_access_ctrl.sv
// RAM access controller: single-port request FSM driving a shared
// bidirectional RAM data bus, with write/read completion counters.
module ram_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_wr_rd_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [7:0]        wr_count,
  output logic [7:0]        rd_count
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic              wr_en_q, wr_en_d;

  // Next-state, latches and registered outputs derived from next state
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_wr) begin
            state_d   = WRITE;
            wr_addr_d = req_addr;
            wdata_d   = req_wdata;
          end else begin
            state_d   = RD_ADDR;
            rd_addr_d = req_addr;
          end
        end
      end
      WRITE: begin
        state_d  = IDLE;
        wr_cnt_d = wr_cnt_q + 8'd1;
      end
      RD_ADDR: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d  = RESP;
        rdata_d  = ram_data;
        rd_cnt_d = rd_cnt_q + 8'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d  = (state_d == IDLE);
    rvalid_d = (state_d == RESP);
    wr_en_d  = (state_d == WRITE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rvalid_q;
  assign rsp_rdata    = rdata_q;
  assign ram_wr_rd_en = wr_en_q;
  assign ram_wr_addr  = wr_addr_q;
  assign ram_rd_addr  = rd_addr_q;
  assign wr_count     = wr_cnt_q;
  assign rd_count     = rd_cnt_q;

  // Bus is driven only while the write strobe is up
  assign ram_data = wr_en_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: directed vector table, corner sequences
// and random traffic against a transaction-level reference model.
module tb_ram_access_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_wr;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;
  wire        req_ready;
  wire        rsp_valid;
  wire  [7:0] rsp_rdata;
  wire        ram_wr_rd_en;
  wire  [3:0] ram_wr_addr;
  wire  [3:0] ram_rd_addr;
  wire  [7:0] ram_data;
  wire  [7:0] wr_count;
  wire  [7:0] rd_count;

  ram_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_wr_rd_en(ram_wr_rd_en), .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr), .ram_data(ram_data),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM device: drives the bus only while the controller is not writing
  logic [7:0] mem [16];
  assign ram_data = ram_wr_rd_en ? 8'bz : mem[ram_rd_addr];
  always @(posedge clk) begin
    if (ram_wr_rd_en) mem[ram_wr_addr] <= ram_data;
  end

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  // Reference model: countdown of busy cycles per operation
  bit         m_known = 0;
  int         m_busy = 0;
  bit         m_rd = 0;
  bit         m_resp = 0;
  logic [3:0] m_wa = 0;
  logic [3:0] m_ra = 0;
  logic [7:0] m_wd = 0;
  logic [7:0] m_rdata = 0;
  int         m_wc = 0;
  int         m_rc = 0;
  logic [7:0] ref_mem [16];

  function automatic bit m_idle();
    return m_known && m_busy == 0 && !m_resp;
  endfunction

  task automatic model_next();
    if (!rst) begin
      if (m_known && m_busy > 0 && !m_rd) ref_mem[m_wa] = m_wd;
      m_busy = 0; m_resp = 0; m_rd = 0;
      m_wa = 0; m_ra = 0; m_wd = 0; m_rdata = 0;
      m_wc = 0; m_rc = 0;
      m_known = 1;
    end else if (!m_known) begin
      m_known = 0;
    end else if (m_idle()) begin
      if (req_valid) begin
        if (req_wr) begin
          m_busy = 1; m_rd = 0; m_wa = req_addr; m_wd = req_wdata;
        end else begin
          m_busy = 2; m_rd = 1; m_ra = req_addr;
        end
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_rd) begin
          m_rdata = ref_mem[m_ra];
          m_rc = (m_rc + 1) % 256;
          m_resp = 1;
        end else begin
          ref_mem[m_wa] = m_wd;
          m_wc = (m_wc + 1) % 256;
        end
      end
    end else if (rsp_ready) begin
      m_resp = 0;
    end
  endtask

  task automatic pre();
    bit wen;
    @(negedge clk);
    if (m_known) begin
      wen = (m_busy > 0) && !m_rd;
      chk("m_ready", req_ready, m_idle());
      chk("m_rvalid", rsp_valid, m_resp);
      chk("m_wren", ram_wr_rd_en, wen);
      chk("m_waddr", ram_wr_addr, m_wa);
      chk("m_raddr", ram_rd_addr, m_ra);
      chk("m_rdata", rsp_rdata, m_rdata);
      chk("m_wcnt", wr_count, m_wc);
      chk("m_rcnt", rd_count, m_rc);
      if (wen) chk("m_bus", ram_data, m_wd);
    end
  endtask

  task automatic post();
    model_next();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // Present a request and hold it until the model says it was taken
  task automatic issue(input bit wr, input logic [3:0] a,
                       input logic [7:0] d);
    bit acc = 0;
    req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      pre();
      acc = m_idle();
      post();
    end
    if (!acc) fail_now("accept_timeout");
    req_valid = 0;
  endtask

  typedef struct {
    bit rn, v, wr;
    logic [3:0] a;
    logic [7:0] d;
    bit rr, ck, rdy, vld, wen;
    logic [3:0] wa, ra;
    logic [7:0] rd, wc, rc, bus;
  } vec_t;

  function automatic vec_t mk(bit rn, bit v, bit wr, logic [3:0] a,
      logic [7:0] d, bit rr, bit ck, bit rdy, bit vld, bit wen,
      logic [3:0] wa, logic [3:0] ra, logic [7:0] rd, logic [7:0] wc,
      logic [7:0] rc, logic [7:0] bus);
    vec_t t;
    t.rn = rn; t.v = v; t.wr = wr; t.a = a; t.d = d; t.rr = rr;
    t.ck = ck; t.rdy = rdy; t.vld = vld; t.wen = wen;
    t.wa = wa; t.ra = ra; t.rd = rd; t.wc = wc; t.rc = rc; t.bus = bus;
    return t;
  endfunction

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit got;
    bit pend;
    bit acc;
    int c0;
    logic [7:0] r0;
    rst = 0; req_valid = 0; req_wr = 0; req_addr = 0;
    req_wdata = 0; rsp_ready = 1;

    // write 3<-A5, write 7<-5A, read 7 with request held while busy
    tbl[0] = mk(0,0,0,0,0,1, 0, 0,0,0, 0,0,8'h00,0,0,8'h00);
    tbl[1] = mk(1,1,1,3,8'hA5,1, 1, 1,0,0, 0,0,8'h00,0,0,8'h00);
    tbl[2] = mk(1,0,0,0,0,1, 1, 0,0,1, 3,0,8'h00,0,0,8'hA5);
    tbl[3] = mk(1,1,1,7,8'h5A,1, 1, 1,0,0, 3,0,8'h00,1,0,8'h00);
    tbl[4] = mk(1,1,0,7,0,1, 1, 0,0,1, 7,0,8'h00,1,0,8'h5A);
    tbl[5] = mk(1,1,0,7,0,1, 1, 1,0,0, 7,0,8'h00,2,0,8'h00);
    tbl[6] = mk(1,0,0,0,0,1, 1, 0,0,0, 7,7,8'h00,2,0,8'h00);
    tbl[7] = mk(1,0,0,0,0,1, 1, 0,0,0, 7,7,8'h00,2,0,8'h00);
    tbl[8] = mk(1,0,0,0,0,1, 1, 0,1,0, 7,7,8'h5A,2,1,8'h00);
    tbl[9] = mk(1,0,0,0,0,1, 1, 1,0,0, 7,7,8'h5A,2,1,8'h00);

    foreach (tbl[i]) begin
      rst = tbl[i].rn; req_valid = tbl[i].v; req_wr = tbl[i].wr;
      req_addr = tbl[i].a; req_wdata = tbl[i].d; rsp_ready = tbl[i].rr;
      pre();
      if (tbl[i].ck) begin
        chk($sformatf("t%0d_ready", i), req_ready, tbl[i].rdy);
        chk($sformatf("t%0d_rvalid", i), rsp_valid, tbl[i].vld);
        chk($sformatf("t%0d_wren", i), ram_wr_rd_en, tbl[i].wen);
        chk($sformatf("t%0d_waddr", i), ram_wr_addr, tbl[i].wa);
        chk($sformatf("t%0d_raddr", i), ram_rd_addr, tbl[i].ra);
        chk($sformatf("t%0d_rdata", i), rsp_rdata, tbl[i].rd);
        chk($sformatf("t%0d_wcnt", i), wr_count, tbl[i].wc);
        chk($sformatf("t%0d_rcnt", i), rd_count, tbl[i].rc);
        if (tbl[i].wen)
          chk($sformatf("t%0d_bus", i), ram_data, tbl[i].bus);
      end
      post();
    end
    req_valid = 0; rst = 1; rsp_ready = 1;

    // read held off by rsp_ready=0 for 4 cycles
    rsp_ready = 0;
    issue(0, 4'd3, 8'h00);
    lat = 0; got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      pre();
      if (rsp_valid) got = 1;
      else begin
        post();
        lat++;
      end
    end
    if (!got) begin
      fail_now("rsp_timeout");
    end else begin
      chk("rd_latency", lat + 1, 3);
      chk("hold_rdata0", rsp_rdata, 8'hA5);
      r0 = rsp_rdata;
      post();
      for (int i = 1; i < 4; i++) begin
        pre();
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, r0);
        chk("hold_ready", req_ready, 0);
        post();
      end
      rsp_ready = 1;
      pre();
      chk("hs_valid", rsp_valid, 1);
      post();
      pre();
      chk("after_hs_ready", req_ready, 1);
      chk("after_hs_valid", rsp_valid, 0);
      post();
    end

    // reset during RD_WAIT aborts the read
    issue(0, 4'd7, 8'h00);
    pre(); post();
    rst = 0;
    pre(); post();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      pre();
      chk("abort_valid", rsp_valid, 0);
      chk("abort_rcnt", rd_count, 0);
      chk("abort_wcnt", wr_count, 0);
      chk("abort_wren", ram_wr_rd_en, 0);
      chk("abort_ready", req_ready, 1);
      post();
    end

    // 256 back-to-back writes wrap the write counter
    c0 = ncyc;
    for (int i = 0; i < 256; i++) begin
      issue(1, 4'(i), 8'($urandom));
    end
    chk("wr_throughput", ncyc - c0, 511);
    pre();
    chk("wr_cnt_255", wr_count, 255);
    post();
    pre();
    chk("wr_cnt_wrap", wr_count, 0);
    post();

    // alternating write/read with valid held
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      issue(1, 4'(i * 3), 8'($urandom));
      issue(0, 4'(i * 3), 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      pre(); post();
    end
    pre();
    chk("alt_wcnt", wr_count, 8);
    chk("alt_rcnt", rd_count, 8);
    post();

    // random traffic against the model
    pend = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!pend && ($urandom % 3 != 0)) begin
        pend = 1;
        req_wr = 1'($urandom);
        req_addr = 4'($urandom);
        req_wdata = 8'($urandom);
      end
      req_valid = pend;
      rsp_ready = 1'($urandom);
      rst = ($urandom % 150 != 0);
      pre();
      acc = pend && rst && m_idle();
      post();
      if (acc) pend = 0;
    end
    rst = 1; req_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      pre(); post();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
